// File: rtl/marquee_scroller_pkg.sv
// Shared encodings for the scrolling-message engine: display modes, control states, status LED.
package marquee_scroller_pkg;

  localparam logic [1:0] MODE_LEFT  = 2'd0;
  localparam logic [1:0] MODE_RIGHT = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_HOLD  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [2:0] RGB_RESET = 3'b001;

  // Rotate right: 001 -> 100 -> 010 -> 001.
  function automatic logic [2:0] rgb_rotate(input logic [2:0] v);
    return {v[0], v[2:1]};
  endfunction

endpackage

// File: rtl/marquee_scroller_step_divider.sv
// Display step divider: counts 0..DIV-1 while enabled, one-cycle tick on the wrapping cycle.
module step_divider #(
  parameter int DIV = 24000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + ONE;
    end
  end

  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/marquee_scroller.sv
// Scrolling-message engine: loads a glyph message, shows a DIGITS-wide window that advances
// every DIV clocks (scroll left/right, blink, hold) and rotates a status LED on each step.
module marquee_scroller
  import marquee_scroller_pkg::*;
#(
  parameter int CHAR_W  = 5,
  parameter int DIGITS  = 4,
  parameter int MSG_MAX = 16,
  parameter int DIV     = 24000000,
  parameter int BLANK   = 31
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 mode,
  input  logic                       pause,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [CHAR_W-1:0]          load_char,
  input  logic                       load_last,
  output logic [DIGITS*CHAR_W-1:0]   data,
  output logic [2:0]                 rgb,
  output logic                       step_pulse
);

  localparam int IW = $clog2(MSG_MAX + 1);
  localparam logic [IW-1:0]     MAX_LEN = IW'(MSG_MAX);
  localparam logic [IW-1:0]     ONE     = IW'(1);
  localparam logic [CHAR_W-1:0] BLANK_C = CHAR_W'(BLANK);

  state_t state, state_nxt;

  logic [CHAR_W-1:0]        msg_buf [MSG_MAX];
  logic [IW-1:0]            len, ptr, wr_idx;
  logic [IW-1:0]            beat_idx, beat_cnt;
  logic                     hidden;
  logic                     accept, first_beat, tick, show;
  logic [IW:0]              sum;
  logic [DIGITS*CHAR_W-1:0] data_nxt;

  assign load_ready = 1'b1;
  assign accept     = load_valid;
  assign first_beat = accept && (state != ST_LOAD);
  assign beat_idx   = first_beat ? '0 : wr_idx;
  // wr_idx saturates at MSG_MAX so overflow beats are counted as dropped, not wrapped.
  assign beat_cnt   = (beat_idx == MAX_LEN) ? MAX_LEN : beat_idx + ONE;

  step_divider #(.DIV(DIV)) u_step_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .en    ((state == ST_RUN) && !pause && !accept),
    .clr   (first_beat),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = load_last ? ST_RUN : ST_LOAD;
  end

  always_comb begin
    step_pulse = 1'b0;
    show       = 1'b0;
    if (state == ST_RUN) begin
      step_pulse = tick;
      show       = !hidden && (len != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (accept && (beat_idx < MAX_LEN)) msg_buf[beat_idx] <= load_char;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len    <= '0;
      ptr    <= '0;
      wr_idx <= '0;
      hidden <= 1'b0;
      rgb    <= RGB_RESET;
    end else if (accept) begin
      if (first_beat) begin
        ptr    <= '0;
        hidden <= 1'b0;
      end
      wr_idx <= beat_cnt;
      if (load_last) len <= beat_cnt;
    end else if (step_pulse) begin
      rgb <= rgb_rotate(rgb);
      case (mode)
        MODE_LEFT:  ptr <= (ptr == len - ONE) ? '0 : ptr + ONE;
        MODE_RIGHT: ptr <= (ptr == '0) ? len - ONE : ptr - ONE;
        default:    ;
      endcase
      hidden <= (mode == MODE_BLINK) ? !hidden : 1'b0;
    end
  end

  // Wrap by a single compare-subtract: ptr+i < 2*len whenever i < len.
  always_comb begin
    data_nxt = {DIGITS{BLANK_C}};
    sum      = '0;
    if (show) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (i < int'(len)) begin
          sum = {1'b0, ptr} + (IW+1)'(i);
          if (sum >= {1'b0, len}) sum = sum - {1'b0, len};
          data_nxt[(DIGITS-1-i)*CHAR_W +: CHAR_W] = msg_buf[IW'(sum)];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data <= {DIGITS{BLANK_C}};
    else        data <= data_nxt;
  end

endmodule

// File: tb/tb_marquee_scroller.sv
// Randomized + directed bench for marquee_scroller against a message-level reference model.
module tb_marquee_scroller;

  localparam int CHAR_W  = 5;
  localparam int DIGITS  = 4;
  localparam int MSG_MAX = 16;
  localparam int DIV     = 4;
  localparam int BLANK   = 31;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [1:0]               mode;
  logic                     pause;
  logic                     load_valid;
  logic                     load_ready;
  logic [CHAR_W-1:0]        load_char;
  logic                     load_last;
  logic [DIGITS*CHAR_W-1:0] data;
  logic [2:0]               rgb;
  logic                     step_pulse;

  always #5 clk = ~clk;

  marquee_scroller #(
    .CHAR_W(CHAR_W), .DIGITS(DIGITS), .MSG_MAX(MSG_MAX), .DIV(DIV), .BLANK(BLANK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .pause      (pause),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_char  (load_char),
    .load_last  (load_last),
    .data       (data),
    .rgb        (rgb),
    .step_pulse (step_pulse)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: message contents, length, display offset, blink state, tick count.
  int          m_buf [MSG_MAX];
  int          m_len, m_ptr, m_cnt, m_beats;
  bit          m_loading, m_running, m_hidden;
  logic [2:0]  m_rgb;
  logic [19:0] m_data;
  logic [1:0]  cur_mode = 2'd0;

  function automatic logic [19:0] window();
    logic [19:0] w;
    for (int i = 0; i < DIGITS; i++) begin
      if (!m_running || m_loading || m_len == 0 || m_hidden || i >= m_len)
        w[(DIGITS-1-i)*CHAR_W +: CHAR_W] = 5'(BLANK);
      else
        w[(DIGITS-1-i)*CHAR_W +: CHAR_W] = 5'(m_buf[(m_ptr + i) % m_len]);
    end
    return w;
  endfunction

  task automatic model_reset();
    m_len = 0; m_ptr = 0; m_cnt = 0; m_beats = 0;
    m_loading = 0; m_running = 0; m_hidden = 0;
    m_rgb = 3'b001;
    m_data = 20'hFFFFF;
  endtask

  task automatic cycle(input bit lv, input int lc, input bit ll, input logic [1:0] md, input bit ps);
    bit          stp;
    logic [19:0] nxt;
    @(negedge clk);
    load_valid = lv; load_char = 5'(lc); load_last = ll; mode = md; pause = ps;
    #1;
    stp = m_running && !m_loading && !ps && !lv && (m_cnt == DIV - 1);
    check_eq("data", 32'(data), 32'(m_data));
    check_eq("rgb", 32'(rgb), 32'(m_rgb));
    check_eq("step_pulse", 32'(step_pulse), 32'(stp));
    check_eq("load_ready", 32'(load_ready), 32'd1);
    nxt = window();
    if (lv) begin
      if (!m_loading) begin
        m_beats = 0; m_ptr = 0; m_cnt = 0; m_hidden = 0;
      end
      if (m_beats < MSG_MAX) m_buf[m_beats] = lc;
      m_beats++;
      if (ll) begin
        m_len = (m_beats < MSG_MAX) ? m_beats : MSG_MAX;
        m_loading = 0; m_running = 1;
      end else begin
        m_loading = 1;
      end
    end else if (m_running && !m_loading && !ps) begin
      if (m_cnt == DIV - 1) begin
        m_cnt = 0;
        m_rgb = {m_rgb[0], m_rgb[2:1]};
        if (md == 2'd0)      m_ptr = (m_ptr + 1) % m_len;
        else if (md == 2'd1) m_ptr = (m_ptr + m_len - 1) % m_len;
        m_hidden = (md == 2'd2) ? !m_hidden : 1'b0;
      end else begin
        m_cnt++;
      end
    end
    m_data = nxt;
  endtask

  task automatic run(input int n, input bit ps);
    for (int k = 0; k < n; k++) cycle(1'b0, 0, 1'b0, cur_mode, ps);
  endtask

  task automatic load_msg(input int n, input int base);
    for (int k = 0; k < n; k++) cycle(1'b1, (base + k) % 32, k == n - 1, cur_mode, 1'b0);
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #2;
    rst_n = 1'b0; load_valid = 1'b0; pause = 1'b0;
    #1;
    check_eq("rst_data", 32'(data), 32'h000FFFFF);
    check_eq("rst_rgb", 32'(rgb), 32'd1);
    check_eq("rst_step", 32'(step_pulse), 32'd0);
    check_eq("rst_ready", 32'(load_ready), 32'd1);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int remaining;
    bit lv, ll, ps;
    rst_n = 1'b0; mode = 2'd0; pause = 1'b0;
    load_valid = 1'b0; load_char = '0; load_last = 1'b0;
    model_reset();
    reset_mid();

    cur_mode = 2'd0; load_msg(6, 0); run(30, 0);
    cur_mode = 2'd1; load_msg(6, 0); run(12, 0);
    cycle(1'b1, 7, 1'b0, cur_mode, 1'b0);
    cycle(1'b1, 9, 1'b1, cur_mode, 1'b0);
    cur_mode = 2'd0; run(10, 0);
    cur_mode = 2'd2; run(20, 0);
    cur_mode = 2'd3; run(12, 0);
    run(10, 1); run(10, 0);
    cur_mode = 2'd0; load_msg(20, 0); run(70, 0);
    // Reload mid-run with idle gaps between beats.
    cycle(1'b1, 3, 1'b0, cur_mode, 1'b0); run(3, 0);
    cycle(1'b1, 4, 1'b0, cur_mode, 1'b1); run(2, 1);
    cycle(1'b1, 5, 1'b1, cur_mode, 1'b0); run(20, 0);
    // Reset in the middle of a load discards the partial message.
    load_msg(3, 10);
    cycle(1'b1, 20, 1'b0, cur_mode, 1'b0);
    reset_mid(); run(8, 0);

    remaining = 0;
    for (int c = 0; c < 2500; c++) begin
      if (c == 1200) reset_mid();
      if (remaining == 0 && $urandom_range(0, 39) == 0) remaining = $urandom_range(1, 20);
      if ($urandom_range(0, 24) == 0) cur_mode = 2'($urandom_range(0, 3));
      ps = ($urandom_range(0, 7) == 0);
      lv = (remaining > 0) && ($urandom_range(0, 2) != 0);
      ll = lv && (remaining == 1);
      if (lv) remaining--;
      cycle(lv, int'($urandom_range(0, 31)), ll, cur_mode, ps);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
